// File: rtl/oam_dma_arbiter_pkg.sv
// Shared GameBoy definitions: memory-map constants, OAM DMA state encoding
// and the common instruction record used across the datapath.
package oam_dma_arbiter_pkg;

   localparam int          OAM_LEN  = 160;
   localparam logic [15:0] DMA_REG  = 16'hFF46;
   localparam logic [15:0] OAM_BASE = 16'hFE00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RD    = 2'd2,
      WR    = 2'd3
   } dma_state_t;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] imm_lo;
      logic [7:0] imm_hi;
      logic [1:0] len;
   } std_instruction_t;

   // Sources in E000-FFFF echo work RAM at C000-DFFF.
   function automatic logic [7:0] echo_src(input logic [7:0] src);
      return (src >= 8'hE0) ? (src - 8'h20) : src;
   endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA sequencer: alternates one read of the source page with one write
// into OAM per byte, restartable at any time by a new trigger.
module oam_dma_engine #(
   parameter int OAM_LEN = oam_dma_arbiter_pkg::OAM_LEN
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        trigger,
   input  logic [7:0]  trig_src,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic        dma_re,
   output logic        dma_we,
   output logic [15:0] dma_addr,
   output logic [7:0]  dma_wdata,
   output logic [7:0]  src_reg
);
   import oam_dma_arbiter_pkg::*;

   localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

   dma_state_t state_reg;
   logic [7:0] idx_reg;
   logic [7:0] src_q_reg;
   logic [7:0] buf_reg;
   logic       busy_reg;
   logic       re_reg;
   logic       we_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         idx_reg   <= 8'h00;
         src_q_reg <= 8'h00;
         buf_reg   <= 8'h00;
         busy_reg  <= 1'b0;
         re_reg    <= 1'b0;
         we_reg    <= 1'b0;
      end else begin
         // The read in flight always lands, even if a restart arrives this cycle.
         if (state_reg == RD)
            buf_reg <= mem_rdata;
         if (trigger) begin
            src_q_reg <= trig_src;
            idx_reg   <= 8'h00;
            state_reg <= START;
            busy_reg  <= 1'b1;
            re_reg    <= 1'b0;
            we_reg    <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  busy_reg <= 1'b0;
                  re_reg   <= 1'b0;
                  we_reg   <= 1'b0;
               end
               START: begin
                  state_reg <= RD;
                  re_reg    <= 1'b1;
                  we_reg    <= 1'b0;
               end
               RD: begin
                  state_reg <= WR;
                  re_reg    <= 1'b0;
                  we_reg    <= 1'b1;
               end
               WR: begin
                  we_reg <= 1'b0;
                  if (idx_reg == LAST_IDX) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end else begin
                     idx_reg   <= idx_reg + 8'h01;
                     state_reg <= RD;
                     re_reg    <= 1'b1;
                  end
               end
               default: begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  re_reg    <= 1'b0;
                  we_reg    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy      = busy_reg;
   assign dma_re    = re_reg;
   assign dma_we    = we_reg;
   assign dma_wdata = buf_reg;
   assign src_reg   = src_q_reg;
   assign dma_addr  = we_reg ? (OAM_BASE + {8'h00, idx_reg})
                             : {echo_src(src_q_reg), idx_reg};

endmodule

// File: rtl/oam_dma_arbiter.sv
// Memory bus arbiter between the CPU datapath and the OAM DMA engine; the DMA
// register itself is decoded here and never reaches the shared bus.
module oam_dma_arbiter #(
   parameter int          OAM_LEN = oam_dma_arbiter_pkg::OAM_LEN,
   parameter logic [15:0] DMA_REG = oam_dma_arbiter_pkg::DMA_REG
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_gnt,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        dma_busy
);

   logic        dma_hit;
   logic        trigger;
   logic        busy;
   logic        dma_re;
   logic        dma_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic [7:0]  src_reg;

   assign dma_hit = cpu_req && (cpu_addr == DMA_REG);
   assign trigger = dma_hit && cpu_we;

   oam_dma_engine #(
      .OAM_LEN (OAM_LEN)
   ) u_engine (
      .clk       (clk),
      .rst       (rst),
      .trigger   (trigger),
      .trig_src  (cpu_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .dma_re    (dma_re),
      .dma_we    (dma_we),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .src_reg   (src_reg)
   );

   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      cpu_gnt   = 1'b0;
      cpu_rdata = 8'hFF;
      // Reset is checked combinationally so the bus is quiet the instant rst drops.
      if (rst) begin
         if (busy) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            mem_re    = dma_re;
            if (dma_hit) begin
               cpu_gnt   = 1'b1;
               cpu_rdata = src_reg;
            end
         end else if (dma_hit) begin
            cpu_gnt   = 1'b1;
            cpu_rdata = src_reg;
         end else begin
            mem_we  = cpu_req & cpu_we;
            mem_re  = cpu_req & ~cpu_we;
            cpu_gnt = cpu_req;
            if (cpu_req)
               cpu_rdata = mem_rdata;
         end
      end
   end

   assign dma_busy = busy;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter with a behavioural 64 KiB memory model.
module tb_oam_dma_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_gnt;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic        dma_busy;

   logic [7:0]  mem [0:65535];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        req;
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        exp_gnt;
      logic [7:0]  exp_rdata;
      logic        exp_re;
      logic        exp_we;
      logic [15:0] exp_maddr;
   } vec_t;

   vec_t vecs [6];

   oam_dma_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rdata (cpu_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_rdata (mem_rdata),
      .dma_busy  (dma_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_we)
         mem[mem_addr] <= mem_wdata;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_cpu(input logic req, input logic we, input logic [15:0] addr,
                          input logic [7:0] wd);
      cpu_req   = req;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Returns at #1 into cycle N+1, where edge N latched the trigger write.
   task automatic trigger_dma(input logic [7:0] src);
      step();
      set_cpu(1'b1, 1'b1, 16'hFF46, src);
      step();
      set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   task automatic check_oam(input string name, input logic [7:0] src_hi);
      for (int i = 0; i < 160; i++)
         chk($sformatf("%s oam[%0d]", name, i), {24'h0, mem[16'hFE00 + 16'(i)]},
             {24'h0, mem[{src_hi, 8'(i)}]});
   endtask

   task automatic dma_run(input logic [7:0] src, input logic [7:0] rd_hi);
      logic [7:0]  idx;
      logic [15:0] ra;
      logic [15:0] wa;
      trigger_dma(src);
      for (int k = 1; k <= 322; k++) begin
         if (k == 100)      set_cpu(1'b1, 1'b0, 16'h8000, 8'h00);
         else if (k == 101) set_cpu(1'b1, 1'b0, 16'hFF46, 8'h00);
         else               set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
         @(negedge clk);
         chk($sformatf("busy src=%h k=%0d", src, k), {31'h0, dma_busy}, {31'h0, (k <= 321)});
         if (k >= 2 && k <= 321) begin
            idx = 8'((k - 2) / 2);
            ra  = {rd_hi, idx};
            wa  = 16'hFE00 + {8'h00, idx};
            if (k % 2 == 0)
               chk($sformatf("rd src=%h k=%0d", src, k), {14'h0, mem_re, mem_we, mem_addr},
                   {14'h0, 1'b1, 1'b0, ra});
            else
               chk($sformatf("wr src=%h k=%0d", src, k),
                   {6'h0, mem_re, mem_we, mem_addr, mem_wdata},
                   {6'h0, 1'b0, 1'b1, wa, mem[ra]});
         end
         if (k == 100)
            chk("blocked read 8000", {23'h0, cpu_gnt, cpu_rdata}, {23'h0, 1'b0, 8'hFF});
         if (k == 101)
            chk("dma reg read busy", {23'h0, cpu_gnt, cpu_rdata}, {23'h0, 1'b1, src});
         if (k == 322)
            chk("bus quiet after dma", {30'h0, mem_re, mem_we}, 32'h0);
         step();
      end
      check_oam($sformatf("copy %h", src), rd_hi);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++)
         mem[a] = 8'h00;
      mem[16'hC000] = 8'h5A;
      mem[16'hC001] = 8'h11;
      mem[16'h8000] = 8'hA7;
      for (int i = 0; i < 160; i++) begin
         mem[16'hC100 + 16'(i)] = 8'(i * 7 + 3);
         mem[16'hC200 + 16'(i)] = 8'(i * 5 + 8'h40);
         mem[16'hC300 + 16'(i)] = 8'hE0 ^ 8'(i);
         mem[16'hD000 + 16'(i)] = 8'(8'hFF - i + 5);
      end

      vecs[0] = '{1'b1, 1'b0, 16'hC000, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 16'hC000};
      vecs[1] = '{1'b1, 1'b1, 16'hC001, 8'h33, 1'b1, 8'h11, 1'b0, 1'b1, 16'hC001};
      vecs[2] = '{1'b1, 1'b0, 16'hC001, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 16'hC001};
      vecs[3] = '{1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 16'h1234};
      vecs[4] = '{1'b1, 1'b0, 16'hFF46, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 16'hFF46};
      vecs[5] = '{1'b1, 1'b0, 16'h8000, 8'h00, 1'b1, 8'hA7, 1'b1, 1'b0, 16'h8000};

      // Reset holds the bus quiet even with a CPU request present.
      rst = 1'b0;
      set_cpu(1'b1, 1'b0, 16'hC000, 8'h00);
      #12;
      chk("reset state", {29'h0, dma_busy, mem_re, mem_we}, 32'h0);
      step();
      step();
      rst = 1'b1;

      for (int v = 0; v < 6; v++) begin
         set_cpu(vecs[v].req, vecs[v].we, vecs[v].addr, vecs[v].wdata);
         @(negedge clk);
         chk($sformatf("vec%0d gnt/rdata", v), {23'h0, cpu_gnt, cpu_rdata},
             {23'h0, vecs[v].exp_gnt, vecs[v].exp_rdata});
         chk($sformatf("vec%0d re/we/busy", v), {29'h0, mem_re, mem_we, dma_busy},
             {29'h0, vecs[v].exp_re, vecs[v].exp_we, 1'b0});
         if (vecs[v].exp_re || vecs[v].exp_we)
            chk($sformatf("vec%0d mem_addr", v), {16'h0, mem_addr}, {16'h0, vecs[v].exp_maddr});
         step();
      end
      set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);

      dma_run(8'hC1, 8'hC1);
      dma_run(8'hE3, 8'hC3);

      // Restart at i = 50, issued during WR(50).
      trigger_dma(8'hC1);
      for (int k = 1; k <= 425; k++) begin
         if (k == 103) set_cpu(1'b1, 1'b1, 16'hFF46, 8'hD0);
         else          set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
         @(negedge clk);
         if (k == 103)
            chk("restart wr FE32", {14'h0, mem_we, cpu_gnt, mem_addr}, {14'h0, 1'b1, 1'b1, 16'hFE32});
         if (k == 104)
            chk("restart start", {29'h0, dma_busy, mem_re, mem_we}, {29'h0, 3'b100});
         if (k == 105)
            chk("restart rd D000", {15'h0, mem_re, mem_addr}, {15'h0, 1'b1, 16'hD000});
         if (k == 106)
            chk("restart wr FE00", {15'h0, mem_we, mem_addr}, {15'h0, 1'b1, 16'hFE00});
         if (k == 424)
            chk("restart busy last", {31'h0, dma_busy}, 32'h1);
         if (k == 425)
            chk("restart idle", {31'h0, dma_busy}, 32'h0);
         step();
      end
      check_oam("restart", 8'hD0);

      // Restart on the final WR, then reset during RD(80) of the new run.
      trigger_dma(8'hC1);
      for (int k = 1; k <= 483; k++) begin
         if (k == 321) set_cpu(1'b1, 1'b1, 16'hFF46, 8'hC2);
         else          set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
         @(negedge clk);
         if (k == 321)
            chk("final wr kept", {15'h0, mem_we, mem_addr}, {15'h0, 1'b1, 16'hFE9F});
         if (k == 322)
            chk("final restart start", {29'h0, dma_busy, mem_re, mem_we}, {29'h0, 3'b100});
         if (k == 323)
            chk("final restart rd", {15'h0, mem_re, mem_addr}, {15'h0, 1'b1, 16'hC200});
         if (k == 483)
            chk("rd i=80", {15'h0, mem_re, mem_addr}, {15'h0, 1'b1, 16'hC250});
         if (k < 483)
            step();
      end
      #1;
      rst = 1'b0;
      set_cpu(1'b1, 1'b0, 16'hC000, 8'h00);
      #1;
      chk("reset mid dma", {29'h0, dma_busy, mem_re, mem_we}, 32'h0);
      step();
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("post reset passthru", {22'h0, cpu_gnt, cpu_rdata, mem_re, dma_busy},
          {22'h0, 1'b1, 8'h5A, 1'b1, 1'b0});
      chk("FE4F written", {24'h0, mem[16'hFE4F]}, {24'h0, mem[16'hC24F]});
      chk("FE50 untouched", {24'h0, mem[16'hFE50]}, {24'h0, mem[16'hC150]});
      step();
      for (int k = 0; k < 20; k++) begin
         set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);
         @(negedge clk);
         chk($sformatf("no resume %0d", k), {30'h0, dma_busy, mem_we}, 32'h0);
         step();
      end
      set_cpu(1'b1, 1'b0, 16'hFF46, 8'h00);
      @(negedge clk);
      chk("src cleared", {23'h0, cpu_gnt, cpu_rdata}, {23'h0, 1'b1, 8'h00});
      step();
      set_cpu(1'b0, 1'b0, 16'h0000, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
